tmr_pc_voter: RTL and testbench

- Word-level triple-modular-redundancy voter. It sits directly upstream of the PC controller.
- Compares the PC and write-back result of the three redundant RISC-V cores every cycle.
- Produces the registered majority PC (PC_voter_output), the majority result, and the 3-bit Voter_state agreement mask that the PC controller consumes; Voter_state==3'b000 is its rollback trigger.
- Tracks persistent per-core disagreement, masks out a faulty core, and escalates to a FAIL state until the recovery sequence reports completion.

---
 rtl/tmr_pc_voter.sv | 169 ++++++++++++++++
 tb/tb_tmr_pc_voter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_pc_voter.sv
// Word-level TMR voter for three redundant cores. It votes on the PC and the
// write-back result, then registers the majority and the agreement mask that
// the PC controller consumes. A core that keeps disagreeing is masked out, and
// voting continues on the two cores that remain. When no usable majority is
// left, the voter enters FAIL and stays there until recovery completes.

module tmr_pc_voter #(
  parameter int WIDTH        = 32,
  parameter int FAULT_THRESH = 3,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic [WIDTH-1:0]  PC_core0,
  input  logic [WIDTH-1:0]  PC_core1,
  input  logic [WIDTH-1:0]  PC_core2,
  input  logic [WIDTH-1:0]  Result_core0,
  input  logic [WIDTH-1:0]  Result_core1,
  input  logic [WIDTH-1:0]  Result_core2,
  input  logic              hold_in,
  input  logic              recovery_done,
  output logic [WIDTH-1:0]  PC_voter_output,
  output logic [WIDTH-1:0]  Result_voter_output,
  output logic [2:0]        Voter_state,
  output logic [2:0]        fault_core,
  output logic              vote_valid,
  output logic [CNT_W-1:0]  mismatch_count
);

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    DEGRADED = 2'd1,
    FAIL     = 2'd2
  } state_t;

  // The consecutive-disagreement counters are 3 bits wide, which covers thresholds up to 7.
  localparam logic [2:0] THRESH = 3'(FAULT_THRESH);

  // Returns {majority_exists, majority_value} over the cores that are still active.
  // With three active cores, any pair that matches decides the vote. With two active
  // cores, both must agree.
  function automatic logic [WIDTH:0] vote_word(
    input logic [WIDTH-1:0] x0,
    input logic [WIDTH-1:0] x1,
    input logic [WIDTH-1:0] x2,
    input logic [2:0]       act
  );
    logic e01, e02, e12;
    e01 = (x0 == x1);
    e02 = (x0 == x2);
    e12 = (x1 == x2);
    vote_word = '0;
    case (act)
      3'b111:  vote_word = {(e01 | e02 | e12), ((e01 | e02) ? x0 : x1)};
      3'b110:  vote_word = {e12, x1};
      3'b101:  vote_word = {e02, x0};
      3'b011:  vote_word = {e01, x0};
      default: vote_word = '0;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         consec_q [3];
  logic [2:0]         consec_d [3];
  logic [WIDTH-1:0]   pc_d, res_d;
  logic [2:0]         vs_d, fault_d;
  logic               vv_d;
  logic [CNT_W-1:0]   cnt_d;

  logic [2:0]         active;
  logic [WIDTH:0]     pc_vote, res_vote;
  logic               pc_ok, res_ok;
  logic [WIDTH-1:0]   pc_maj, res_maj;
  logic [2:0]         agree;
  logic               usable;

  assign active   = ~fault_core;
  assign pc_vote  = vote_word(PC_core0, PC_core1, PC_core2, active);
  assign res_vote = vote_word(Result_core0, Result_core1, Result_core2, active);
  assign pc_ok    = pc_vote[WIDTH];
  assign pc_maj   = pc_vote[WIDTH-1:0];
  assign res_ok   = res_vote[WIDTH];
  assign res_maj  = res_vote[WIDTH-1:0];

  // A core agrees only if it matches both field majorities. A cross split therefore leaves a single bit set.
  assign agree[0] = active[0] & pc_ok & res_ok & (PC_core0 == pc_maj) & (Result_core0 == res_maj);
  assign agree[1] = active[1] & pc_ok & res_ok & (PC_core1 == pc_maj) & (Result_core1 == res_maj);
  assign agree[2] = active[2] & pc_ok & res_ok & (PC_core2 == pc_maj) & (Result_core2 == res_maj);

  assign usable   = (agree[0] & agree[1]) | (agree[0] & agree[2]) | (agree[1] & agree[2]);

  // Next-state and next-output logic. By default everything holds and vote_valid drops.
  always_comb begin
    state_d  = state_q;
    pc_d     = PC_voter_output;
    res_d    = Result_voter_output;
    vs_d     = Voter_state;
    fault_d  = fault_core;
    vv_d     = 1'b0;
    cnt_d    = mismatch_count;
    consec_d = consec_q;

    case (state_q)
      NORMAL, DEGRADED: begin
        if (!hold_in) begin
          if ((agree != active) && (mismatch_count != {CNT_W{1'b1}})) begin
            cnt_d = mismatch_count + 1'b1;
          end
          if (!usable) begin
            state_d = FAIL;
            vs_d    = 3'b000;
          end else begin
            pc_d  = pc_maj;
            res_d = res_maj;
            vs_d  = agree;
            vv_d  = 1'b1;
            if (state_q == NORMAL) begin
              for (int i = 0; i < 3; i++) begin
                if (agree[i]) begin
                  consec_d[i] = 3'd0;
                end else if ((consec_q[i] + 3'd1) == THRESH) begin
                  consec_d[i] = 3'd0;
                  fault_d[i]  = 1'b1;
                  state_d     = DEGRADED;
                end else begin
                  consec_d[i] = consec_q[i] + 3'd1;
                end
              end
            end
          end
        end
      end
      default: begin
        // Any code outside NORMAL/DEGRADED behaves as FAIL. The voter waits for recovery and ignores hold_in.
        vs_d = 3'b000;
        if (recovery_done) begin
          state_d  = NORMAL;
          fault_d  = 3'b000;
          consec_d = '{default: 3'd0};
          vs_d     = 3'b111;
        end
      end
    endcase
  end

  // State and output registers. Reset puts the mask at 111 so the controller never sees a spurious rollback.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q             <= NORMAL;
      consec_q            <= '{default: 3'd0};
      PC_voter_output     <= '0;
      Result_voter_output <= '0;
      Voter_state         <= 3'b111;
      fault_core          <= 3'b000;
      vote_valid          <= 1'b0;
      mismatch_count      <= '0;
    end else begin
      state_q             <= state_d;
      consec_q            <= consec_d;
      PC_voter_output     <= pc_d;
      Result_voter_output <= res_d;
      Voter_state         <= vs_d;
      fault_core          <= fault_d;
      vote_valid          <= vv_d;
      mismatch_count      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tmr_pc_voter.sv
// Scoreboard bench for tmr_pc_voter. The driver applies one input set per cycle.
// It steps a behavioural model and queues the expected registered outputs.
// A monitor pops one entry after every rising edge and compares it with the DUT.

module tb_tmr_pc_voter;

  localparam int WIDTH  = 32;
  localparam int THRESH = 3;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_in;
  logic [WIDTH-1:0]  pc0, pc1, pc2, res0, res1, res2;
  logic              hold_in, recovery_done;
  logic [WIDTH-1:0]  pc_out, res_out;
  logic [2:0]        voter_state, fault_core;
  logic              vote_valid;
  logic [CNT_W-1:0]  mismatch_count;

  typedef struct {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] res;
    logic [2:0]       vs;
    logic [2:0]       fault;
    logic             vv;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural model state: mode 0 = normal, 1 = one core masked, 2 = failed.
  int               mode;
  bit   [2:0]       m_fault;
  int               m_consec[3];
  logic [WIDTH-1:0] m_pc, m_res;
  logic [2:0]       m_vs;
  bit               m_vv;
  int               m_cnt;

  tmr_pc_voter #(.WIDTH(WIDTH), .FAULT_THRESH(THRESH), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst_in              (rst_in),
    .PC_core0            (pc0),
    .PC_core1            (pc1),
    .PC_core2            (pc2),
    .Result_core0        (res0),
    .Result_core1        (res1),
    .Result_core2        (res2),
    .hold_in             (hold_in),
    .recovery_done       (recovery_done),
    .PC_voter_output     (pc_out),
    .Result_voter_output (res_out),
    .Voter_state         (voter_state),
    .fault_core          (fault_core),
    .vote_valid          (vote_valid),
    .mismatch_count      (mismatch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A value is the majority if at least two active cores carry it.
  task automatic sharedValue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] c, input bit [2:0] act,
                             output bit ok, output logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] x[3];
    int n;
    x[0] = a; x[1] = b; x[2] = c;
    ok = 1'b0;
    v  = '0;
    for (int i = 0; i < 3; i++) begin
      if (act[i]) begin
        n = 0;
        for (int j = 0; j < 3; j++) if (act[j] && x[j] == x[i]) n++;
        if (n >= 2) begin ok = 1'b1; v = x[i]; end
      end
    end
  endtask

  task automatic modelStep(input bit rst, input bit hold, input bit rec);
    bit [2:0] act, m;
    bit okp, okr;
    logic [WIDTH-1:0] vp, vr;
    logic [WIDTH-1:0] p[3], r[3];
    p[0] = pc0; p[1] = pc1; p[2] = pc2;
    r[0] = res0; r[1] = res1; r[2] = res2;
    if (rst) begin
      mode = 0; m_fault = 3'b000; m_pc = '0; m_res = '0; m_vs = 3'b111;
      m_vv = 1'b0; m_cnt = 0;
      for (int i = 0; i < 3; i++) m_consec[i] = 0;
    end else if (mode == 2) begin
      m_vv = 1'b0;
      if (rec) begin
        mode = 0; m_fault = 3'b000; m_vs = 3'b111;
        for (int i = 0; i < 3; i++) m_consec[i] = 0;
      end else begin
        m_vs = 3'b000;
      end
    end else if (hold) begin
      m_vv = 1'b0;
    end else begin
      act = ~m_fault;
      sharedValue(pc0, pc1, pc2, act, okp, vp);
      sharedValue(res0, res1, res2, act, okr, vr);
      for (int i = 0; i < 3; i++) m[i] = act[i] && okp && okr && p[i] == vp && r[i] == vr;
      if (m != act && m_cnt < CNT_MAX) m_cnt++;
      if ($countones(m) < 2) begin
        mode = 2; m_vs = 3'b000; m_vv = 1'b0;
      end else begin
        m_pc = vp; m_res = vr; m_vs = m; m_vv = 1'b1;
        if (mode == 0) begin
          for (int i = 0; i < 3; i++) begin
            if (m[i]) m_consec[i] = 0;
            else begin
              m_consec[i]++;
              if (m_consec[i] == THRESH) begin
                m_consec[i] = 0; m_fault[i] = 1'b1; mode = 1;
              end
            end
          end
        end
      end
    end
  endtask

  // Drives one cycle of inputs, then queues the outputs the model expects after the next edge.
  task automatic applyStimulus(input bit rst, input bit hold, input bit rec,
                               input logic [WIDTH-1:0] p0, input logic [WIDTH-1:0] p1,
                               input logic [WIDTH-1:0] p2, input logic [WIDTH-1:0] r0,
                               input logic [WIDTH-1:0] r1, input logic [WIDTH-1:0] r2);
    exp_t e;
    @(negedge clk);
    rst_in = rst; hold_in = hold; recovery_done = rec;
    pc0 = p0; pc1 = p1; pc2 = p2; res0 = r0; res1 = r1; res2 = r2;
    modelStep(rst, hold, rec);
    e.pc = m_pc; e.res = m_res; e.vs = m_vs; e.fault = m_fault; e.vv = m_vv;
    e.cnt = m_cnt[CNT_W-1:0];
    exp_q.push_back(e);
  endtask

  task automatic good(input bit hold, input bit rec);
    applyStimulus(1'b0, hold, rec, 32'h100, 32'h100, 32'h100, 32'h5, 32'h5, 32'h5);
  endtask

  task automatic checkField(input string name, input logic [WIDTH-1:0] got,
                            input logic [WIDTH-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("PC_voter_output", pc_out, e.pc);
    checkField("Result_voter_output", res_out, e.res);
    checkField("Voter_state", WIDTH'(voter_state), WIDTH'(e.vs));
    checkField("fault_core", WIDTH'(fault_core), WIDTH'(e.fault));
    checkField("vote_valid", WIDTH'(vote_valid), WIDTH'(e.vv));
    checkField("mismatch_count", WIDTH'(mismatch_count), WIDTH'(e.cnt));
  endtask

  // Monitor: after every rising edge, pop the pending expectation and compare it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  // One randomized cycle. Values come from a small pool so that coincidental agreement is common.
  int bad_core = 1;
  task automatic randomCycle(input bit allow_rst);
    logic [WIDTH-1:0] p[3], r[3];
    logic [WIDTH-1:0] bp, br;
    int pat, other;
    bit rst, hold, rec;
    bp = 32'h1000 + 32'($urandom_range(0, 3)) * 4;
    br = 32'($urandom_range(0, 7));
    for (int i = 0; i < 3; i++) begin p[i] = bp; r[i] = br; end
    if ($urandom_range(0, 19) == 0) bad_core = $urandom_range(0, 2);
    other = (bad_core + 1 + $urandom_range(0, 1)) % 3;
    pat = $urandom_range(0, 9);
    case (pat)
      4, 5: p[bad_core] = bp ^ 32'h40;
      6:    r[bad_core] = br ^ 32'h8;
      7:    begin p[bad_core] = bp ^ 32'h40; r[other] = br ^ 32'h8; end
      8:    begin p[0] = bp ^ 32'h40; p[1] = bp ^ 32'h80; end
      9:    begin p[bad_core] = bp ^ 32'h40; r[bad_core] = br ^ 32'h8; end
      default: ;
    endcase
    rst  = allow_rst && ($urandom_range(0, 99) == 0);
    hold = ($urandom_range(0, 9) == 0);
    rec  = ($urandom_range(0, 3) == 0);
    applyStimulus(rst, hold, rec, p[0], p[1], p[2], r[0], r[1], r[2]);
  endtask

  initial begin
    rst_in = 1'b1; hold_in = 1'b0; recovery_done = 1'b0;
    pc0 = '0; pc1 = '0; pc2 = '0; res0 = '0; res1 = '0; res2 = '0;

    // Reset, then four agreeing cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h100, 32'h100, 32'h100, 32'h5, 32'h5, 32'h5);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h100, 32'h100, 32'h100, 32'h5, 32'h5, 32'h5);
    repeat (4) good(1'b0, 1'b0);

    // A single stray PC on core 1, then three in a row, which masks core 1.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h100, 32'h104, 32'h100, 32'h5, 32'h5, 32'h5);
    good(1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h100, 32'h104, 32'h100, 32'h5, 32'h5, 32'h5);
    good(1'b0, 1'b1);

    // The two remaining cores split on the result, so the voter fails. hold_in is ignored in FAIL.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h100, 32'h100, 32'h100, 32'h5, 32'h5, 32'h6);
    good(1'b1, 1'b0);
    good(1'b0, 1'b1);
    good(1'b0, 1'b0);

    // Cross split: core 0 is wrong on the PC and core 2 on the result.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h200, 32'h100, 32'h100, 32'h5, 32'h5, 32'h9);
    good(1'b0, 1'b1);
    good(1'b0, 1'b0);

    // Hold for two cycles while the PCs change, then vote normally.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 32'h304, 32'h308, 32'h1, 32'h2, 32'h3);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h400, 32'h100, 32'h100, 32'h5, 32'h5, 32'h5);
    good(1'b0, 1'b0);

    // Fail, then reset while still in FAIL.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h200, 32'h100, 32'h100, 32'h5, 32'h5, 32'h9);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h200, 32'h100, 32'h100, 32'h5, 32'h5, 32'h9);
    good(1'b0, 1'b0);

    // A long random run without reset drives mismatch_count into saturation.
    repeat (1500) randomCycle(1'b0);
    // A random run with occasional resets.
    repeat (500) randomCycle(1'b1);
    good(1'b0, 1'b0);

    // Drain the scoreboard, allowing only a bounded number of extra cycles.
    repeat (4) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
